// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (data load/store + read-only fetch) onto one single-port SRAM.
// Data has priority; fetch is forced through after STARVE_LIMIT consecutive denied cycles.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_be,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,

    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,

    output logic                  mem_enable,
    output logic                  mem_write_enable,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W-1:0]     mem_write_data,
    output logic [DATA_W/8-1:0]   mem_byte_enable,
    input  logic [DATA_W-1:0]     mem_read_data,

    output logic                  starved
);

    typedef enum logic [1:0] {
        IDLE,
        RD_DATA,
        RD_FETCH
    } owner_t;

    owner_t              r_owner;
    logic [3:0]          r_starve_cnt;
    logic [DATA_W-1:0]   r_d_hold;
    logic [DATA_W-1:0]   r_i_hold;
    logic                w_starved;
    logic                w_d_gnt;
    logic                w_i_gnt;

    assign w_starved = (r_starve_cnt == 4'(STARVE_LIMIT));

    // Grants are gated by rst_n so the SRAM port is idle for the whole reset window.
    always_comb begin
        w_i_gnt = rst_n && i_req && (!d_req || w_starved);
        w_d_gnt = rst_n && d_req && !w_i_gnt;
    end

    assign d_gnt   = w_d_gnt;
    assign i_gnt   = w_i_gnt;
    assign starved = w_starved;

    always_comb begin
        mem_enable       = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_byte_enable  = '1;
        if (w_d_gnt) begin
            mem_enable       = 1'b1;
            mem_write_enable = d_we;
            mem_address      = d_addr;
            mem_write_data   = d_wdata;
            mem_byte_enable  = d_be;
        end else if (w_i_gnt) begin
            mem_enable       = 1'b1;
            mem_address      = i_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= IDLE;
            r_starve_cnt <= '0;
            r_d_hold     <= '0;
            r_i_hold     <= '0;
        end else begin
            if (w_i_gnt)
                r_owner <= RD_FETCH;
            else if (w_d_gnt && !d_we)
                r_owner <= RD_DATA;
            else
                r_owner <= IDLE;

            if (i_req && !w_i_gnt)
                r_starve_cnt <= w_starved ? r_starve_cnt : r_starve_cnt + 4'd1;
            else
                r_starve_cnt <= '0;

            if (r_owner == RD_DATA)
                r_d_hold <= mem_read_data;
            if (r_owner == RD_FETCH)
                r_i_hold <= mem_read_data;
        end
    end

    // Read data passes straight through in the response cycle, then the capture holds it.
    always_comb begin
        d_rvalid = (r_owner == RD_DATA);
        i_rvalid = (r_owner == RD_FETCH);
        d_rdata  = d_rvalid ? mem_read_data : r_d_hold;
        i_rdata  = i_rvalid ? mem_read_data : r_i_hold;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 32, width of all data ports; byte-enable width = DATA_W/8.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive denied fetch cycles before fetch gets forced priority (range 1..15).
REQ-004 SHALL have one clock and an asynchronous active-low reset, with ports as follows.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
REQ-005 SHALL have these data-requester ports (memory stage).
- d_req  in  1  access request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  byte address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  byte enables.
- d_gnt  out  1  request accepted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  DATA_W  load data.
REQ-006 SHALL have these fetch-requester ports (read-only).
- i_req  in  1  fetch request.
- i_addr  in  ADDR_W  fetch address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch data valid.
- i_rdata  out  DATA_W  fetched word.
REQ-007 SHALL have these single-port SRAM master ports.
- mem_enable  out  1  access strobe.
- mem_write_enable  out  1  write strobe.
- mem_address  out  ADDR_W  address.
- mem_write_data  out  DATA_W  write data.
- mem_byte_enable  out  DATA_W/8  byte lanes.
- mem_read_data  in  DATA_W  read data, valid 1 cycle after a read strobe.
REQ-008 SHALL have starved  out  1, high while the forced-fetch-priority condition holds.

Function
REQ-009 SHALL compute grants combinationally in the cycle of the request; at most one of d_gnt/i_gnt SHALL be high in any cycle.
REQ-010 SHALL grant data over fetch when both request, unless starve_cnt == STARVE_LIMIT, in which case fetch SHALL win.
REQ-011 SHALL drive the SRAM port from the granted requester in the grant cycle: enable=1; write_enable=d_we for data, 0 for fetch; byte_enable=d_be for data, all ones for fetch; write_data=d_wdata for data, 0 for fetch.
REQ-012 SHALL, with no grant, drive mem_enable=0, mem_write_enable=0, mem_address=0, mem_write_data=0, mem_byte_enable=all ones.
REQ-013 SHALL hold registered state owner_q in {IDLE, RD_DATA, RD_FETCH}: next = RD_DATA on a data-load grant, RD_FETCH on a fetch grant, otherwise IDLE (stores -> IDLE).
REQ-014 SHALL assert d_rvalid exactly when owner_q == RD_DATA and i_rvalid exactly when owner_q == RD_FETCH; read latency = 1 cycle from grant.
REQ-015 SHALL drive d_rdata/i_rdata from mem_read_data while the matching rvalid is high, and hold the last delivered value otherwise (registered capture).
REQ-016 SHALL keep 4-bit starve_cnt: +1 each cycle i_req && !i_gnt, saturating at STARVE_LIMIT; cleared to 0 on i_gnt or !i_req.
REQ-017 SHALL assert starved = (starve_cnt == STARVE_LIMIT).
REQ-018 SHALL support back-to-back grants every cycle, including a grant in the same cycle as a previous read's rvalid.
REQ-019 SHALL require requesters to hold req and payload stable until granted; a dropped request SHALL simply not be granted.

Reset
REQ-020 SHALL, while rst_n is low, force d_gnt=0, i_gnt=0, all mem_* strobes per REQ-012, owner_q=IDLE, d_rvalid=0, i_rvalid=0, starve_cnt=0, starved=0, d_rdata=0, i_rdata=0.
REQ-021 SHALL, on reset assertion mid-read, discard the pending read; no rvalid after rst_n returns high.

Verification
REQ-022 Data load alone, d_addr=0x100 -> d_gnt same cycle, mem_enable=1, mem_address=0x100; next cycle d_rvalid=1, d_rdata=mem_read_data.
REQ-023 Store d_addr=0x40, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_write_enable=1, mem_byte_enable=4'b0011; no d_rvalid next cycle.
REQ-024 d_req and i_req held high continuously, STARVE_LIMIT=4 -> d_gnt 4 cycles, starved=1 in 5th cycle with i_gnt=1, then data resumes.
REQ-025 Alternating data load/fetch each cycle -> rvalid routed to correct owner each cycle, no overlap.
REQ-026 Fetch granted, rst_n low next cycle before rvalid -> i_rvalid stays 0 during and after reset, all outputs at reset values.
